// File: rtl/music_sequencer_if.sv
// Note-ROM read port between the score sequencer and its synchronous table ROM.
// The ROM registers rom_data on an edge where it samples rom_rd high and holds it until the next read.
interface music_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [13:0]       rom_data;

    modport master (output rom_rd, output rom_addr, input rom_data);
    modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/music_sequencer.sv
// Score sequencer: walks a note table in the external ROM and drives the tone generator's
// scale code, holding each note for its length in tempo ticks plus an optional rest gap.
//
// state | meaning
// IDLE  | not playing, outputs quiet
// FETCH | rom_rd strobed for the current address
// WAIT  | ROM read in flight
// LOAD  | entry sampled and decoded (note, rest or end marker)
// PLAY  | note sounding, length counter runs on tempo ticks
// GAP   | articulation rest after a note
module music_sequencer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SPEED     = 8,
    parameter int ADDR_W    = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
    input  logic [ADDR_W-1:0]  song_base,
    music_sequencer_if.master  rom,
    output logic [5:0]         scale,
    output logic               note_strobe,
    output logic               busy,
    output logic               done
);
    localparam int TICK_DIV = CLK_HZ / SPEED;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS);
    localparam logic [5:0]       END_MARK = 6'd63;
    localparam logic [5:0]       TOP_NOTE = 6'd21;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rd_q, rd_d;
    logic [5:0]        scale_q, scale_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [7:0]        len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic [5:0] entry_scale;
    logic [7:0] entry_len;
    logic       tick;
    logic       timing_state;

    assign entry_scale  = rom.rom_data[13:8];
    assign entry_len    = rom.rom_data[7:0];
    assign tick         = (div_q == DIV_LAST);
    assign timing_state = (state_q == S_PLAY) || (state_q == S_GAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            rd_q     <= 1'b0;
            scale_q  <= 6'd0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= '0;
            len_q    <= 8'd0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            rd_q     <= rd_d;
            scale_q  <= scale_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div_q    <= div_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        rd_d     = 1'b0;
        scale_d  = scale_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div_d    = div_q;
        len_d    = len_q;
        gap_d    = gap_q;

        if (stop) begin
            state_d = S_IDLE;
            scale_d = 6'd0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        addr_d  = song_base;
                        base_d  = song_base;
                        rd_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_LOAD;
                S_LOAD: begin
                    if (entry_scale == END_MARK) begin
                        if (loop_en) begin
                            state_d = S_FETCH;
                            addr_d  = base_q;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            scale_d = 6'd0;
                        end
                    end else begin
                        // codes above the high octave are timed but silent
                        scale_d  = (entry_scale <= TOP_NOTE) ? entry_scale : 6'd0;
                        strobe_d = 1'b1;
                        len_d    = (entry_len == 8'd0) ? 8'd1 : entry_len;
                        div_d    = '0;
                        state_d  = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!pause) begin
                        if (tick) begin
                            div_d = '0;
                            if (len_q == 8'd1) begin
                                if (GAP_TICKS > 0) begin
                                    scale_d = 6'd0;
                                    gap_d   = GAP_INIT;
                                    state_d = S_GAP;
                                end else begin
                                    addr_d  = addr_q + 1'b1;
                                    rd_d    = 1'b1;
                                    state_d = S_FETCH;
                                end
                            end else begin
                                len_d = len_q - 8'd1;
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (!pause) begin
                        if (tick) begin
                            div_d = '0;
                            if (gap_q == GAP_W'(1)) begin
                                addr_d  = addr_q + 1'b1;
                                rd_d    = 1'b1;
                                state_d = S_FETCH;
                            end else begin
                                gap_d = gap_q - 1'b1;
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // pause silences the output without disturbing the held note code
    assign scale        = (pause && timing_state) ? 6'd0 : scale_q;
    assign note_strobe  = strobe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rom.rom_rd   = rd_q;
    assign rom.rom_addr = addr_q;
endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: note entries are queued as expected strobes and
// checked when the DUT applies them; timing, pause, loop, stop and reset are checked inline.
module tb_music_sequencer;
    typedef struct {
        logic [5:0] scale;
        logic [7:0] addr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0, loop_en = 1'b0;
    logic       start1 = 1'b0, stop1 = 1'b0, start2 = 1'b0, stop2 = 1'b0;
    logic [7:0] song_base1 = 8'd0;
    logic [1:0] song_base2 = 2'd0;
    logic [5:0] scale1, scale2;
    logic       strobe1, strobe2, busy1, busy2, done1, done2;
    logic       dsel = 1'b0;
    logic [5:0] scale_s;
    logic       strobe_s;

    logic [13:0] rom1 [256];
    logic [13:0] rom2 [4];
    exp_t q1[$], q2[$];
    exp_t e1, e2;
    int checks = 0, failures = 0, done_cnt1 = 0;

    music_sequencer_if #(.ADDR_W(8)) if1 ();
    music_sequencer_if #(.ADDR_W(2)) if2 ();

    music_sequencer #(.CLK_HZ(16), .SPEED(4), .ADDR_W(8), .GAP_TICKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .pause(pause), .loop_en(loop_en),
        .song_base(song_base1), .rom(if1.master), .scale(scale1), .note_strobe(strobe1),
        .busy(busy1), .done(done1));

    music_sequencer #(.CLK_HZ(16), .SPEED(4), .ADDR_W(2), .GAP_TICKS(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .pause(pause), .loop_en(loop_en),
        .song_base(song_base2), .rom(if2.master), .scale(scale2), .note_strobe(strobe2),
        .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if1.rom_rd) if1.rom_data <= rom1[if1.rom_addr];
        if (if2.rom_rd) if2.rom_data <= rom2[if2.rom_addr];
    end

    assign scale_s  = dsel ? scale2 : scale1;
    assign strobe_s = dsel ? strobe2 : strobe1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && strobe1) begin
            chk("d1_strobe_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("d1_strobe_scale", 32'(scale1), 32'(e1.scale));
                chk("d1_strobe_addr", 32'(if1.rom_addr), 32'(e1.addr));
            end
        end
        if (!rst && strobe2) begin
            chk("d2_strobe_expected", 32'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                chk("d2_strobe_scale", 32'(scale2), 32'(e2.scale));
                chk("d2_strobe_addr", 32'(if2.rom_addr), 32'(e2.addr));
            end
        end
        if (!rst && done1) done_cnt1++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        if (dsel) start2 = 1'b1;
        else      start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_strobe(input int limit, output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (!strobe_s && cycles < limit);
    endtask

    task automatic run_len(input logic [5:0] val, input int limit, output int cycles);
        cycles = 0;
        while (scale_s === val && cycles < limit) begin
            cycles++;
            step(1);
        end
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (!done1 && cycles < limit);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cnt12, end_idx, paused_loud;
        foreach (rom1[i]) rom1[i] = {6'd63, 8'd0};
        rom1[0] = {6'd10, 8'd2};
        rom1[1] = {6'd63, 8'd0};
        rom1[5] = {6'd3, 8'd1};
        rom2[3] = {6'd25, 8'd1};
        rom2[0] = {6'd5, 8'd0};
        rom2[1] = {6'd1, 8'd2};
        rom2[2] = {6'd21, 8'd1};

        step(3);
        chk("reset_outputs", 32'({scale1, if1.rom_rd, if1.rom_addr, strobe1, busy1, done1}), 0);
        rst = 1'b0;
        step(1);

        // single note then end marker
        q1.push_back('{6'd10, 8'd0});
        pulse_start();
        chk("t1_rom_rd", 32'(if1.rom_rd), 1);
        chk("t1_busy", 32'(busy1), 1);
        wait_strobe(20, c);
        chk("t1_start_to_strobe", c, 3);
        run_len(6'd10, 50, c);
        chk("t1_note_clks", c, 8);
        chk("t1_gap_addr", 32'(if1.rom_addr), 0);
        wait_done(50, c);
        chk("t1_gap_fetch_to_done", c, 7);
        chk("t1_busy_at_done", 32'(busy1), 0);
        chk("t1_scale_at_done", 32'(scale1), 0);
        step(1);
        chk("t1_done_one_cycle", 32'(done1), 0);
        chk("t1_done_count", done_cnt1, 1);

        // start while busy with a different song_base is ignored
        q1.push_back('{6'd10, 8'd0});
        pulse_start();
        wait_strobe(20, c);
        song_base1 = 8'd5;
        pulse_start();
        song_base1 = 8'd0;
        chk("t6_busy_start_addr", 32'(if1.rom_addr), 0);
        run_len(6'd10, 50, c);
        chk("t6_busy_start_note_rest", c, 7);
        wait_done(50, c);
        chk("t6_busy_start_done", c, 7);
        step(1);
        chk("t6_done_count", done_cnt1, 2);

        // looping, then stop mid-PLAY
        rom1[0] = {6'd8, 8'd1};
        loop_en = 1'b1;
        repeat (3) q1.push_back('{6'd8, 8'd0});
        pulse_start();
        wait_strobe(40, c);
        chk("t3_first_strobe", c, 3);
        wait_strobe(40, c);
        chk("t3_loop_period_a", c, 14);
        wait_strobe(40, c);
        chk("t3_loop_period_b", c, 14);
        stop1 = 1'b1;
        step(1);
        stop1 = 1'b0;
        chk("t4_stop_busy", 32'(busy1), 0);
        chk("t4_stop_scale", 32'(scale1), 0);
        chk("t4_stop_rom_rd", 32'(if1.rom_rd), 0);
        loop_en = 1'b0;
        step(2);
        chk("t4_stop_no_done", done_cnt1, 2);

        // start and stop together in IDLE
        start1 = 1'b1;
        stop1 = 1'b1;
        step(1);
        start1 = 1'b0;
        stop1 = 1'b0;
        chk("t4_startstop_busy", 32'(busy1), 0);
        chk("t4_startstop_rom_rd", 32'(if1.rom_rd), 0);
        wait_strobe(6, c);
        chk("t4_startstop_no_strobe", c, 6);

        // pause for 5 clocks starting at clock 2 of a 3-tick note
        rom1[0] = {6'd12, 8'd3};
        q1.push_back('{6'd12, 8'd0});
        pulse_start();
        wait_strobe(20, c);
        chk("t2_start_to_strobe", c, 3);
        cnt12 = 0;
        end_idx = -1;
        paused_loud = 0;
        for (int i = 0; i < 30; i++) begin
            pause = (i >= 2 && i < 7);
            #1;
            if (scale1 === 6'd12) cnt12++;
            if (pause && scale1 !== 6'd0) paused_loud++;
            if (!pause && scale1 === 6'd0 && end_idx < 0) end_idx = i;
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
        chk("t2_clks_at_12", cnt12, 12);
        chk("t2_paused_silent", paused_loud, 0);
        chk("t2_note_end_clk", end_idx, 17);
        step(1);
        chk("t2_done_count", done_cnt1, 3);
        chk("t2_idle_busy", 32'(busy1), 0);

        // edge entries on a 2-bit address ROM starting at 3, wrapping
        dsel = 1'b1;
        song_base2 = 2'd3;
        q2.push_back('{6'd0, 8'd3});
        q2.push_back('{6'd5, 8'd0});
        q2.push_back('{6'd1, 8'd1});
        q2.push_back('{6'd21, 8'd2});
        q2.push_back('{6'd0, 8'd3});
        pulse_start();
        wait_strobe(30, c);
        chk("t5_start_to_strobe", c, 3);
        wait_strobe(30, c);
        chk("t5_rest_entry_period", c, 11);
        run_len(6'd5, 30, c);
        chk("t5_len0_note_clks", c, 4);
        wait_strobe(30, c);
        chk("t5_len0_tail", c, 7);
        wait_strobe(30, c);
        chk("t5_len2_period", c, 15);
        wait_strobe(30, c);
        chk("t5_wrap_period", c, 11);
        stop2 = 1'b1;
        step(1);
        stop2 = 1'b0;
        chk("t5_stop_busy", 32'(busy2), 0);
        dsel = 1'b0;

        // reset in the middle of a note
        rom1[0] = {6'd10, 8'd2};
        q1.push_back('{6'd10, 8'd0});
        pulse_start();
        wait_strobe(20, c);
        step(2);
        chk("t6_mid_note_scale", 32'(scale1), 10);
        rst = 1'b1;
        step(1);
        chk("t6_rst_outputs", 32'({scale1, if1.rom_rd, if1.rom_addr, strobe1, busy1, done1}), 0);
        rst = 1'b0;
        step(10);
        chk("t6_rst_stays_idle", 32'({busy1, scale1}), 0);
        chk("t6_rst_no_done", done_cnt1, 3);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
